map_leaf_elastic: RTL

Next-generation generic leaf map node for TyBEC-generated kernels. It joins two operand streams and applies a parametrised integer operator through an LAT-stage pipeline. Results are buffered in an internal output FIFO, and the block uses credit-based input acceptance, so no data is lost or duplicated under back-pressure. It sits between upstream stream sources or other leaf nodes and a downstream consumer with a valid/ready interface.

---
 rtl/map_leaf_elastic_pkg.sv | 19 +
 rtl/map_leaf_fwft_fifo.sv | 71 +++++++
 rtl/map_leaf_elastic.sv | 114 +++++++++++
 3 files changed

// File: rtl/map_leaf_elastic_pkg.sv
// Shared definitions for TyBEC leaf map nodes: operator encodings and a
// constant-foldable ceil(log2) used to size pointers and counters.
package map_leaf_elastic_pkg;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_MUL  = 2;
    localparam int OP_PASS = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/map_leaf_fwft_fifo.sv
// First-word-fall-through FIFO; the head entry is visible on dout_o whenever
// the FIFO is non-empty, and dout_o reads as zero while empty.
module map_leaf_fwft_fifo
    import map_leaf_elastic_pkg::*;
#(
    parameter int STREAMW    = 34,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [STREAMW-1:0]           din_i,
    input  logic                         pop_i,
    output logic [STREAMW-1:0]           dout_o,
    output logic [clog2(FIFO_DEPTH):0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int AW = clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [STREAMW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/map_leaf_elastic.sv
// Elastic leaf map node: joins two operand streams, applies OP through a
// non-stalling LAT-stage pipeline and buffers results in a FWFT FIFO.
module map_leaf_elastic
    import map_leaf_elastic_pkg::*;
#(
    parameter int                 STREAMW     = 34,
    parameter int                 LAT         = 4,
    parameter int                 OP          = 0,
    parameter int                 USE_CONST_B = 0,
    parameter logic [STREAMW-1:0] CONST_B     = '0,
    parameter int                 FIFO_DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [STREAMW-1:0]           in1_s0,
    input  logic                         ivalid_in1_s0,
    input  logic [STREAMW-1:0]           in2_s0,
    input  logic                         ivalid_in2_s0,
    output logic                         iready,
    output logic [STREAMW-1:0]           out1_s0,
    output logic                         ovalid,
    input  logic                         oready,
    output logic [clog2(FIFO_DEPTH):0]   occupancy
);

    localparam int CW = clog2(FIFO_DEPTH) + 1;

    logic [STREAMW-1:0] op_b;
    logic [STREAMW-1:0] res;
    logic               ivalid;
    logic               fire_in;
    logic               fire_out;
    logic [LAT-1:0]     vld_q, vld_d;
    logic [STREAMW-1:0] dat_q [LAT];
    logic [CW-1:0]      in_flight;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_push;

    if (USE_CONST_B != 0) begin : g_const_b
        assign op_b   = CONST_B;
        assign ivalid = ivalid_in1_s0;
    end else begin : g_stream_b
        assign op_b   = in2_s0;
        assign ivalid = ivalid_in1_s0 & ivalid_in2_s0;
    end

    // Results are truncated to STREAMW bits, so all operators wrap mod 2^STREAMW.
    always_comb begin
        res = in1_s0;
        case (OP)
            OP_ADD:  res = in1_s0 + op_b;
            OP_SUB:  res = in1_s0 - op_b;
            OP_MUL:  res = in1_s0 * op_b;
            default: res = in1_s0;
        endcase
    end

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < LAT; i++) begin
            in_flight = in_flight + CW'(vld_q[i]);
        end
    end

    // Every accepted pair reserves a FIFO slot up front, so the pipeline never
    // needs to stall and iready depends only on internal state and reset.
    assign occupancy = fifo_count + in_flight;
    assign iready    = rst & (occupancy < CW'(FIFO_DEPTH));
    assign fire_in   = ivalid & iready;
    assign fire_out  = ovalid & oready;
    assign ovalid    = ~fifo_empty;
    assign fifo_push = vld_q[LAT-1] & ~fifo_full;

    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = fire_in;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        dat_q[0] <= res;
        for (int i = 1; i < LAT; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    map_leaf_fwft_fifo #(
        .STREAMW    (STREAMW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (fifo_push),
        .din_i   (dat_q[LAT-1]),
        .pop_i   (fire_out),
        .dout_o  (out1_s0),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

endmodule
